// File: rtl/serial_cmd_decoder.sv
// Byte-level command decoder: edge-detects rx_done into byte strobes, parses
// mode/payload/write commands, echoes every byte and times out stalled commands.
module serial_cmd_decoder #(
  parameter int PAYLOAD_BYTES = 9,
  parameter int DATA_W        = 72,
  parameter int TIMEOUT_TICKS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              rx_done,
  input  logic [7:0]        rx_byte,
  output logic [1:0]        mode,
  output logic [DATA_W-1:0] intensities,
  output logic              pat_we,
  output logic [7:0]        pat_addr,
  output logic [DATA_W-1:0] pat_data,
  output logic              echo_go,
  output logic [7:0]        echo_byte,
  output logic              err
);
  localparam int CNT_W = $clog2(PAYLOAD_BYTES + 1);

  localparam logic [7:0] C_R = 8'h72, C_S = 8'h73, C_I = 8'h69, C_A = 8'h61;
  localparam logic [7:0] C_P = 8'h70, C_W = 8'h77, C_U = 8'h75;

  typedef enum logic [1:0] {IDLE, PAYLOAD, ADDR} st_t;

  st_t               st, st_n;
  logic              rx_done_l;
  logic              byte_valid;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [7:0]        to_cnt, to_n;
  // Only the bytes before the last one need holding; the last byte joins
  // directly into payload_q on commit.
  logic [DATA_W-9:0] shift_q, shift_n;
  logic [DATA_W-1:0] payload_q, pay_n, int_n;
  logic [1:0]        mode_n;
  logic [7:0]        addr_n, eb_n;
  logic              we_n, echo_n, err_n;

  assign byte_valid = rx_done & ~rx_done_l;
  assign pat_data   = payload_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_done_l   <= 1'b1;
      st          <= IDLE;
      cnt         <= '0;
      to_cnt      <= '0;
      shift_q     <= '0;
      payload_q   <= '0;
      mode        <= '0;
      intensities <= '0;
      pat_addr    <= '0;
      pat_we      <= 1'b0;
      echo_go     <= 1'b0;
      echo_byte   <= '0;
      err         <= 1'b0;
    end else begin
      rx_done_l   <= rx_done;
      st          <= st_n;
      cnt         <= cnt_n;
      to_cnt      <= to_n;
      shift_q     <= shift_n;
      payload_q   <= pay_n;
      mode        <= mode_n;
      intensities <= int_n;
      pat_addr    <= addr_n;
      pat_we      <= we_n;
      echo_go     <= echo_n;
      echo_byte   <= eb_n;
      err         <= err_n;
    end
  end

  always_comb begin
    st_n    = st;
    cnt_n   = cnt;
    to_n    = to_cnt;
    shift_n = shift_q;
    pay_n   = payload_q;
    mode_n  = mode;
    int_n   = intensities;
    addr_n  = pat_addr;
    we_n    = 1'b0;
    echo_n  = 1'b0;
    eb_n    = echo_byte;
    err_n   = 1'b0;
    if (byte_valid) begin
      // A byte always beats a coincident tick, including the timeout tick.
      echo_n = 1'b1;
      eb_n   = rx_byte;
      to_n   = '0;
      case (st)
        IDLE: begin
          case (rx_byte)
            C_R:     mode_n = 2'd1;
            C_S:     mode_n = 2'd2;
            C_I:     mode_n = 2'd3;
            C_A:     mode_n = 2'd0;
            C_P:     begin cnt_n = '0; st_n = PAYLOAD; end
            C_W:     st_n = ADDR;
            C_U:     int_n = payload_q;
            default: err_n = 1'b1;
          endcase
        end
        PAYLOAD: begin
          shift_n = {shift_q[DATA_W-17:0], rx_byte};
          cnt_n   = cnt + 1'b1;
          if (cnt == CNT_W'(PAYLOAD_BYTES - 1)) begin
            pay_n = {shift_q, rx_byte};
            st_n  = IDLE;
          end
        end
        ADDR: begin
          addr_n = rx_byte;
          we_n   = 1'b1;
          st_n   = IDLE;
        end
        default: st_n = IDLE;
      endcase
    end else if (tick && st != IDLE) begin
      if (to_cnt == 8'(TIMEOUT_TICKS - 1)) begin
        st_n  = IDLE;
        to_n  = '0;
        err_n = 1'b1;
      end else begin
        to_n = to_cnt + 8'd1;
      end
    end
  end
endmodule
